div_iter: RTL and testbench

Parametrised multi-cycle iterative divider for the execute stage, backing DIV/DIVU. It takes operands from the ex stage, runs a one-bit-per-cycle restoring division and returns {remainder, quotient} for the HI/LO write path. It also produces the busy signal that ex turns into a pipeline stall request. Unlike the single-cycle ex datapath, it is sequential, handshaked and abortable, covering branch-delay annul.

---
 rtl/div_iter_pkg.sv | 38 +++
 rtl/div_iter_step.sv | 43 ++++
 rtl/div_iter.sv | 237 +++++++++++++++++++++++
 tb/tb_div_iter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative divider and its ex-stage client:
//   - div_state_e       : divider FSM state encoding
//   - DivResultReady /
//     DivResultNotReady : levels of the ready_o handshake
//   - DivStart/DivStop  : levels of the start_i request from ex
//   - EXE_DIV_OP /
//     EXE_DIVU_OP       : ex->div opcode select, with decode helpers
// -----------------------------------------------------------------------------
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // True when the ex-stage ALU opcode must be routed to the divider.
    function automatic logic div_op_sel(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

    // Signed-mode select derived from the ex-stage opcode.
    function automatic logic div_op_signed(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// -----------------------------------------------------------------------------
// div_iter_step (module div_step)
// One restoring-division slice: compares the shifted partial remainder with
// the divisor and subtracts when it fits.
// Ports:
//   rem_i   in  WIDTH+1  partial remainder already shifted left with the next
//                        dividend bit
//   dvs_i   in  WIDTH    divisor magnitude
//   rem_o   out WIDTH    next partial remainder (always < divisor)
//   qbit_o  out 1        quotient bit produced by this step
// -----------------------------------------------------------------------------
import div_iter_pkg::*;

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] w_diff;
    logic           w_fits;

    assign w_diff = rem_i - {1'b0, dvs_i};
    assign w_fits = (rem_i >= {1'b0, dvs_i});

    // Restore (keep the old remainder) when the divisor does not fit. The
    // upper bit is dropped because the kept value is always below 2^WIDTH.
    always_comb begin
        rem_o  = rem_i[WIDTH-1:0];
        qbit_o = 1'b0;
        if (w_fits) begin
            rem_o  = w_diff[WIDTH-1:0];
            qbit_o = 1'b1;
        end else begin
            rem_o  = rem_i[WIDTH-1:0];
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle,
// result returned as {remainder (HI), quotient (LO)}. busy_o feeds the ex
// stall request; annul_i aborts an operation in flight (branch-delay annul).
// Configuration macro: DIV_ZERO_FAST_EN
//   defined   : a zero divisor takes the BYZERO fast path (ready in cycle 2)
//   undefined : a zero divisor runs the full iteration, result forced to 0
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned (sampled in FREE only)
//   opdata1_i     dividend          (sampled in FREE only)
//   opdata2_i     divisor           (sampled in FREE only)
//   start_i       request, held by ex until the result is consumed
//   annul_i       abort (ignored once the result is ready)
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   busy_o        operation in progress, registered
//   dbz_o         divide-by-zero flag, valid with ready_o, registered
// -----------------------------------------------------------------------------
import div_iter_pkg::*;

module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);

    // State and datapath registers. r_dvd starts as the dividend magnitude
    // and is shifted left each step while quotient bits enter at the bottom,
    // so after WIDTH steps it holds the quotient magnitude.
    div_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_negq;
    logic               r_negr;
    logic               r_zero;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_dbz;

    div_state_e         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_dvd_nxt;
    logic [WIDTH-1:0]   w_dvs_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic               w_negq_nxt;
    logic               w_negr_nxt;
    logic               w_zero_nxt;
    logic [2*WIDTH-1:0] w_result_nxt;
    logic               w_dbz_nxt;
    logic               w_ready_nxt;
    logic               w_busy_nxt;

    logic               w_sgn1;
    logic               w_sgn2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_qbit;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_accept;

    // Operand signs only matter in signed mode. Negating the most negative
    // value wraps to itself, which read as unsigned is its correct magnitude.
    assign w_sgn1   = signed_div_i & opdata1_i[WIDTH-1];
    assign w_sgn2   = signed_div_i & opdata2_i[WIDTH-1];
    assign w_mag1   = w_sgn1 ? (~opdata1_i + {{(WIDTH-1){1'b0}}, 1'b1}) : opdata1_i;
    assign w_mag2   = w_sgn2 ? (~opdata2_i + {{(WIDTH-1){1'b0}}, 1'b1}) : opdata2_i;
    assign w_accept = (start_i == DivStart) && !annul_i;

    assign w_partial = {r_rem, r_dvd[WIDTH-1]};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (w_partial),
        .dvs_i  (r_dvs),
        .rem_o  (w_step_rem),
        .qbit_o (w_step_qbit)
    );

    // Sign fix-up: quotient negative when signs differ, remainder follows
    // the dividend. Flags are already cleared for unsigned operations.
    assign w_quo_fix = r_negq ? (~r_dvd + {{(WIDTH-1){1'b0}}, 1'b1}) : r_dvd;
    assign w_rem_fix = r_negr ? (~r_rem + {{(WIDTH-1){1'b0}}, 1'b1}) : r_rem;

    // Next-state, datapath and output logic of the divider FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dvd_nxt    = r_dvd;
        w_dvs_nxt    = r_dvs;
        w_rem_nxt    = r_rem;
        w_negq_nxt   = r_negq;
        w_negr_nxt   = r_negr;
        w_zero_nxt   = r_zero;
        w_result_nxt = r_result;
        w_dbz_nxt    = r_dbz;

        case (r_state)
            DIV_FREE: begin
                w_result_nxt = {(2*WIDTH){1'b0}};
                w_dbz_nxt    = 1'b0;
                if (w_accept) begin
                    w_dvd_nxt  = w_mag1;
                    w_dvs_nxt  = w_mag2;
                    w_rem_nxt  = {WIDTH{1'b0}};
                    w_cnt_nxt  = {CNT_W{1'b0}};
                    w_negq_nxt = w_sgn1 ^ w_sgn2;
                    w_negr_nxt = w_sgn1;
                    w_zero_nxt = (opdata2_i == {WIDTH{1'b0}});
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        w_state_nxt = DIV_BYZERO;
                    end else begin
                        w_state_nxt = DIV_ON;
                    end
`else
                    w_state_nxt = DIV_ON;
`endif
                end else begin
                    w_state_nxt = DIV_FREE;
                end
            end

`ifdef DIV_ZERO_FAST_EN
            DIV_BYZERO: begin
                if (annul_i) begin
                    w_state_nxt  = DIV_FREE;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                    w_dbz_nxt    = 1'b0;
                end else begin
                    w_state_nxt  = DIV_END;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                    w_dbz_nxt    = 1'b1;
                end
            end
`endif

            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt  = DIV_FREE;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                    w_dbz_nxt    = 1'b0;
                end else if (r_cnt != CNT_W'(WIDTH)) begin
                    w_rem_nxt = w_step_rem;
                    w_dvd_nxt = {r_dvd[WIDTH-2:0], w_step_qbit};
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt = DIV_END;
                    w_dbz_nxt   = r_zero;
                    // A zero divisor only reaches ON in the slow build;
                    // its iteration result is meaningless and is dropped.
                    if (r_zero) begin
                        w_result_nxt = {(2*WIDTH){1'b0}};
                    end else begin
                        w_result_nxt = {w_rem_fix, w_quo_fix};
                    end
                end
            end

            DIV_END: begin
                if (start_i == DivStop) begin
                    w_state_nxt  = DIV_FREE;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                    w_dbz_nxt    = 1'b0;
                end else begin
                    w_state_nxt = DIV_END;
                end
            end

            default: begin
                w_state_nxt  = DIV_FREE;
                w_result_nxt = {(2*WIDTH){1'b0}};
                w_dbz_nxt    = 1'b0;
            end
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        w_ready_nxt = (w_state_nxt == DIV_END) ? DivResultReady : DivResultNotReady;
        w_busy_nxt  = (w_state_nxt == DIV_ON) || (w_state_nxt == DIV_BYZERO);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DIV_FREE;
            r_cnt    <= {CNT_W{1'b0}};
            r_dvd    <= {WIDTH{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
            r_ready  <= DivResultNotReady;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dvd    <= w_dvd_nxt;
            r_dvs    <= w_dvs_nxt;
            r_rem    <= w_rem_nxt;
            r_negq   <= w_negq_nxt;
            r_negr   <= w_negr_nxt;
            r_zero   <= w_zero_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;
    assign dbz_o    = r_dbz;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Directed plus randomised checks of div_iter at WIDTH=32 and WIDTH=8 against
// a reference built from plain signed/unsigned integer division.
// -----------------------------------------------------------------------------
module tb_div_iter;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT32 = 2;
    localparam int ZLAT8  = 2;
`else
    localparam int ZLAT32 = 34;
    localparam int ZLAT8  = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sdiv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;
    logic        dbz;

    logic        s8_sdiv;
    logic [7:0]  s8_op1;
    logic [7:0]  s8_op2;
    logic        s8_start;
    logic        s8_annul;
    logic [15:0] s8_result;
    logic        s8_ready;
    logic        s8_busy;
    logic        s8_dbz;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sdiv),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
        .dbz_o        (dbz)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s8_sdiv),
        .opdata1_i    (s8_op1),
        .opdata2_i    (s8_op2),
        .start_i      (s8_start),
        .annul_i      (s8_annul),
        .result_o     (s8_result),
        .ready_o      (s8_ready),
        .busy_o       (s8_busy),
        .dbz_o        (s8_dbz)
    );

    // Reference: truncating integer division on w-bit operands, results
    // reduced modulo 2^w; zero divisor yields 0.
    function automatic logic [63:0] ref_div(input bit sgn, input longint a,
                                            input longint b, input int w);
        longint m, half, sa, sb, q, r;
        logic [63:0] res;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        if (b == 0) return 64'd0;
        sa = a;
        sb = b;
        if (sgn) begin
            if (a >= half) sa = a - (m + 1);
            if (b >= half) sb = b - (m + 1);
        end
        q   = sa / sb;
        r   = sa % sb;
        res = (64'(r & m) << w) | 64'(q & m);
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next clock cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete 32-bit transaction: start in cycle 0, wait for ready,
    // hold the result (with an ignored annul pulse), then release.
    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [63:0] exp;
        int          lat;
        int          cyc;
        int          busy_n;
        exp    = ref_div(sgn, longint'(a), longint'(b), 32);
        lat    = (b == 32'd0) ? ZLAT32 : 34;
        sdiv   = sgn;
        op1    = a;
        op2    = b;
        start  = 1'b1;
        annul  = 1'b0;
        cyc    = 0;
        busy_n = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (busy === 1'b1) busy_n++;
            sdiv = 1'($urandom);
            op1  = $urandom;
            op2  = $urandom;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " dbz"}, 64'(dbz), 64'(b == 32'd0));
        check({tag, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
        check({tag, " busy at ready"}, 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            annul = (i == 2);
            tick();
            check({tag, " hold"}, {ready, result}, {1'b1, exp});
        end
        annul = 1'b0;
        start = 1'b0;
        tick();
        check({tag, " release"}, {61'd0, ready, busy, dbz}, 64'd0);
        check({tag, " release result"}, result, 64'd0);
    endtask

    // Same flow for the WIDTH=8 instance.
    task automatic do_op8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                          input string tag);
        logic [63:0] exp;
        int          lat;
        int          cyc;
        exp      = ref_div(sgn, longint'(a), longint'(b), 8);
        lat      = (b == 8'd0) ? ZLAT8 : 10;
        s8_sdiv  = sgn;
        s8_op1   = a;
        s8_op2   = b;
        s8_start = 1'b1;
        cyc      = 0;
        while (s8_ready !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " result"}, 64'(s8_result), exp);
        check({tag, " dbz"}, 64'(s8_dbz), 64'(b == 8'd0));
        s8_start = 1'b0;
        tick();
        check({tag, " release"}, {45'd0, s8_ready, s8_busy, s8_result}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          cyc;

        rst = 1'b1; sdiv = 1'b0; op1 = 32'd0; op2 = 32'd0; start = 1'b1; annul = 1'b0;
        s8_sdiv = 1'b0; s8_op1 = 8'd0; s8_op2 = 8'd0; s8_start = 1'b1; s8_annul = 1'b0;
        tick();
        tick();
        check("reset 32", {ready, busy, dbz, result}, 67'd0);
        check("reset 8", {45'd0, s8_ready, s8_busy, s8_dbz, s8_result}, 64'd0);
        start = 1'b0;
        s8_start = 1'b0;
        rst = 1'b0;
        tick();

        // Directed cases
        do_op(1'b0, 32'd100, 32'd7, "u100/7");
        check("u100/7 value", ref_div(1'b0, 100, 7, 32), 64'h00000002_0000000E);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, "s-7/2");
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, "s7/-2");
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "sMIN/-1");
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, "uMIN/-1");
        do_op(1'b0, 32'h00001234, 32'd0, "div0");
        do_op(1'b1, 32'hFFFF0000, 32'd0, "sdiv0");

        // Annul in cycle 10, restart with 9/3 in cycle 11
        sdiv = 1'b0; op1 = $urandom; op2 = 32'd5; start = 1'b1; annul = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("annul pre ready", 64'(ready), 64'd0);
        end
        annul = 1'b1;
        tick();
        check("annul free", {ready, busy, dbz, result}, 67'd0);
        annul = 1'b0; op1 = 32'd9; op2 = 32'd3;
        cyc = 11;
        while (ready !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("restart latency", 64'(cyc), 64'd45);
        check("restart result", result, 64'h00000000_00000003);
        start = 1'b0;
        tick();

        // Reset dominates a running operation and a held start
        sdiv = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("mid reset", {ready, busy, dbz, result}, 67'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();

        // Randomised 32-bit operations
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            case (sel)
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       begin rb = 32'hFFFFFFFF; ra = 32'h80000000; end
                default: rb = $urandom;
            endcase
            do_op(1'($urandom), ra, rb, "rand32");
        end

        // WIDTH=8 instance
        do_op8(1'b0, 8'd200, 8'd9, "u8 200/9");
        check("u8 200/9 value", ref_div(1'b0, 200, 9, 8), 64'h0216);
        do_op8(1'b1, 8'h80, 8'hFF, "s8 MIN/-1");
        do_op8(1'b0, 8'h55, 8'd0, "u8 div0");
        for (int i = 0; i < 10; i++) begin
            do_op8(1'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), "rand8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
